// File: rtl/alu_pkg.sv
// Shared constants, opcodes and types for the EX->MEM pipeline register.
// Payload layout matches the ALU output bundle carried between stages.
package alu_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [OP_W-1:0] OP_AND = 3'd2;
    localparam logic [OP_W-1:0] OP_OR  = 3'd3;

    typedef enum logic [1:0] {
        EX_EMPTY = 2'd0,
        EX_FULL  = 2'd1,
        EX_SKID  = 2'd2
    } ex_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] res;
        logic              zero;
        logic [OP_W-1:0]   op;
        logic [REG_AW-1:0] rd;
        logic              wb_en;
    } ex_payload_t;

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// Valid/ready stream carrying one ALU result bundle.
// master drives valid+payload, slave drives ready.
interface ex_mem_pipe_reg_if import alu_pkg::*; ();

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] res;
    logic              zero;
    logic [OP_W-1:0]   op;
    logic [REG_AW-1:0] rd;
    logic              wb_en;

    modport master (output valid, res, zero, op, rd, wb_en, input ready);
    modport slave  (input valid, res, zero, op, rd, wb_en, output ready);

endinterface

// File: rtl/ex_mem_pipe_reg_slot.sv
// Enable-loaded payload register, used for the head entry and the skid entry.
module ex_pipe_slot import alu_pkg::*; (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  ex_payload_t d,
    output ex_payload_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with forwarding tap. Build option EX_SKID_EN adds a
// second (skid) entry so in_ready can be registered without losing throughput.
//
// state    | meaning
// EX_EMPTY | no entry held, out_valid=0
// EX_FULL  | head entry valid
// EX_SKID  | head + skid valid, in_ready=0 (EX_SKID_EN only)
module ex_mem_pipe_reg import alu_pkg::*; (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    ex_mem_pipe_reg_if.slave    in_bus,
    ex_mem_pipe_reg_if.master   out_bus,
    output logic                fwd_valid,
    output logic [REG_AW-1:0]   fwd_rd,
    output logic [DATA_W-1:0]   fwd_data
);

    ex_state_t   state_q, state_d;
    ex_payload_t in_pl, head_q, head_d;
    logic        head_en;
    logic        out_valid, in_xfer, out_xfer;

    assign in_pl     = '{res: in_bus.res, zero: in_bus.zero, op: in_bus.op,
                         rd: in_bus.rd, wb_en: in_bus.wb_en};
    assign out_valid = (state_q != EX_EMPTY);
    assign in_xfer   = in_bus.valid & in_bus.ready;
    assign out_xfer  = out_valid & out_bus.ready;

`ifdef EX_SKID_EN
    ex_payload_t skid_q;
    logic        skid_en;
    logic        in_ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EX_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != EX_SKID);
        end
    end

    always_comb begin
        state_d = state_q;
        head_en = 1'b0;
        skid_en = 1'b0;
        head_d  = in_pl;
        if (flush) begin
            state_d = EX_EMPTY;
        end else begin
            case (state_q)
                EX_EMPTY: if (in_xfer) begin
                    state_d = EX_FULL;
                    head_en = 1'b1;
                end
                EX_FULL: if (in_xfer && out_xfer) begin
                    head_en = 1'b1;
                end else if (in_xfer) begin
                    state_d = EX_SKID;
                    skid_en = 1'b1;
                end else if (out_xfer) begin
                    state_d = EX_EMPTY;
                end
                EX_SKID: if (out_xfer) begin
                    state_d = EX_FULL;
                    head_en = 1'b1;
                    head_d  = skid_q;
                end
                default: state_d = EX_EMPTY;
            endcase
        end
    end

    ex_pipe_slot u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (in_pl),
        .q     (skid_q)
    );

    assign in_bus.ready = in_ready_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EX_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Head is replaced in the same cycle it drains, so one register suffices.
    always_comb begin
        state_d = state_q;
        head_en = 1'b0;
        head_d  = in_pl;
        if (flush) begin
            state_d = EX_EMPTY;
        end else if (in_xfer) begin
            state_d = EX_FULL;
            head_en = 1'b1;
        end else if (out_xfer) begin
            state_d = EX_EMPTY;
        end
    end

    assign in_bus.ready = !out_valid || out_bus.ready;
`endif

    ex_pipe_slot u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (head_en),
        .d     (head_d),
        .q     (head_q)
    );

    assign out_bus.valid = out_valid;
    assign out_bus.res   = head_q.res;
    assign out_bus.zero  = head_q.zero;
    assign out_bus.op    = head_q.op;
    assign out_bus.rd    = head_q.rd;
    assign out_bus.wb_en = head_q.wb_en;

    assign fwd_valid = out_valid & head_q.wb_en;
    assign fwd_rd    = head_q.rd;
    assign fwd_data  = head_q.res;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Self-checking bench for ex_mem_pipe_reg: queue model with capacity rules plus
// directed literal checks; works with or without EX_SKID_EN defined.
module tb_ex_mem_pipe_reg;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic              fwd_valid;
    logic [REG_AW-1:0] fwd_rd;
    logic [DATA_W-1:0] fwd_data;

    ex_mem_pipe_reg_if in_if ();
    ex_mem_pipe_reg_if out_if ();

    ex_mem_pipe_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_bus    (in_if),
        .out_bus   (out_if),
        .fwd_valid (fwd_valid),
        .fwd_rd    (fwd_rd),
        .fwd_data  (fwd_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    ex_payload_t mq[$];

`ifdef EX_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic model_in_ready();
`ifdef EX_SKID_EN
        return mq.size() < CAP;
`else
        return (mq.size() == 0) || out_if.ready;
`endif
    endfunction

    // Model: FIFO of accepted entries; pop on out transfer, push on in transfer.
    always @(posedge clk) begin : model_upd
        logic rdy;
        ex_payload_t p;
        if (rst_n) begin
            rdy = model_in_ready();
            if (flush) begin
                mq.delete();
            end else begin
                if (mq.size() != 0 && out_if.ready) void'(mq.pop_front());
                if (in_if.valid && rdy) begin
                    p.res = in_if.res; p.zero = in_if.zero; p.op = in_if.op;
                    p.rd = in_if.rd; p.wb_en = in_if.wb_en;
                    mq.push_back(p);
                end
            end
        end
    end

    always @(negedge rst_n) mq.delete();

    always @(negedge clk) begin
        chk("out_valid", {31'd0, out_if.valid}, {31'd0, mq.size() != 0});
        chk("in_ready", {31'd0, in_if.ready}, {31'd0, model_in_ready()});
        if (mq.size() != 0) begin
            chk("fwd_valid", {31'd0, fwd_valid}, {31'd0, mq[0].wb_en});
            chk("out_res", {16'd0, out_if.res}, {16'd0, mq[0].res});
            chk("out_zero", {31'd0, out_if.zero}, {31'd0, mq[0].zero});
            chk("out_op", {29'd0, out_if.op}, {29'd0, mq[0].op});
            chk("out_rd", {29'd0, out_if.rd}, {29'd0, mq[0].rd});
            chk("out_wb_en", {31'd0, out_if.wb_en}, {31'd0, mq[0].wb_en});
            chk("fwd_rd", {29'd0, fwd_rd}, {29'd0, mq[0].rd});
            chk("fwd_data", {16'd0, fwd_data}, {16'd0, mq[0].res});
        end else begin
            chk("fwd_valid_empty", {31'd0, fwd_valid}, 32'd0);
        end
    end

    task automatic drive(input logic v, input logic [15:0] r, input logic z, input logic [2:0] o,
                         input logic [2:0] d, input logic w, input logic ordy, input logic fl);
        in_if.valid = v; in_if.res = r; in_if.zero = z; in_if.op = o;
        in_if.rd = d; in_if.wb_en = w; out_if.ready = ordy; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 0, 0);
        #12 rst_n = 1'b1;
        step();
        chk("rst_out_valid", {31'd0, out_if.valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_if.ready}, 32'd1);
        chk("rst_res", {16'd0, out_if.res}, 32'd0);

        // Stream with no backpressure: one result per cycle, 1-cycle latency.
        for (int i = 0; i < 6; i++) begin
            drive(1, 16'h0003 + 16'(i), (i == 2), OP_ADD, 3'(i), 1, 1, 0);
            step();
            chk("stream_valid", {31'd0, out_if.valid}, 32'd1);
            chk("stream_res", {16'd0, out_if.res}, 32'h3 + 32'(i));
        end
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 1, 0);
        step();
        chk("stream_drained", {31'd0, out_if.valid}, 32'd0);

        // Asynchronous reset mid-stream.
        drive(1, 16'h00AA, 0, OP_AND, 3'd1, 1, 0, 0);
        step();
        chk("pre_rst_valid", {31'd0, out_if.valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_if.valid}, 32'd0);
        chk("async_rst_fwd", {31'd0, fwd_valid}, 32'd0);
        chk("async_rst_ready", {31'd0, in_if.ready}, 32'd1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 0, 0);
        step();

        // Backpressure.
        drive(1, 16'hEC8D, 0, OP_SUB, 3'd1, 1, 0, 0);
        step();
        chk("bp_res1", {16'd0, out_if.res}, 32'hEC8D);
`ifdef EX_SKID_EN
        chk("bp_ready1", {31'd0, in_if.ready}, 32'd1);
        drive(1, 16'h1234, 1, OP_SUB, 3'd2, 1, 0, 0);
        step();
        chk("bp_ready2", {31'd0, in_if.ready}, 32'd0);
        chk("bp_hold", {16'd0, out_if.res}, 32'hEC8D);
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 0, 0);
        step();
        chk("bp_hold2", {16'd0, out_if.res}, 32'hEC8D);
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 1, 0);
        step();
`else
        chk("bp_ready1", {31'd0, in_if.ready}, 32'd0);
        drive(1, 16'h1234, 1, OP_SUB, 3'd2, 1, 0, 0);
        step();
        chk("bp_hold", {16'd0, out_if.res}, 32'hEC8D);
        drive(1, 16'h1234, 1, OP_SUB, 3'd2, 1, 1, 0);
        step();
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 1, 0);
`endif
        chk("bp_second", {16'd0, out_if.res}, 32'h1234);
        chk("bp_second_zero", {31'd0, out_if.zero}, 32'd1);
        step();
        chk("bp_empty", {31'd0, out_if.valid}, 32'd0);

        // Flush with entries held and a simultaneous input.
        drive(1, 16'h1111, 0, OP_ADD, 3'd3, 1, 0, 0);
        step();
        drive(1, 16'h2222, 0, OP_ADD, 3'd4, 1, 0, 0);
        step();
        drive(1, 16'hBAD0, 0, OP_OR, 3'd7, 1, 1, 1);
        step();
        chk("flush_valid", {31'd0, out_if.valid}, 32'd0);
        chk("flush_ready", {31'd0, in_if.ready}, 32'd1);
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("flush_no_stray", {31'd0, out_if.valid}, 32'd0);
        end

        // Forwarding tap.
        drive(1, 16'h7FF8, 0, OP_OR, 3'd5, 1, 0, 0);
        step();
        chk("fwd_valid1", {31'd0, fwd_valid}, 32'd1);
        chk("fwd_rd5", {29'd0, fwd_rd}, 32'd5);
        chk("fwd_data", {16'd0, fwd_data}, 32'h7FF8);
        drive(1, 16'h0101, 0, OP_AND, 3'd2, 0, 1, 0);
        step();
        chk("fwd_off_valid", {31'd0, out_if.valid}, 32'd1);
        chk("fwd_off", {31'd0, fwd_valid}, 32'd0);
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 1, 0);
        step();

        // Random valid/ready/flush traffic against the queue model.
        for (int i = 0; i < 10000; i++) begin
            logic [15:0] a, b;
            a = 16'($urandom_range(3));
            b = 16'($urandom_range(3));
            drive(1'($urandom_range(1)), a + b, (a == b), 3'($urandom_range(3)),
                  3'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  ($urandom_range(63) == 0));
            step();
        end
        drive(0, 16'h0, 0, OP_ADD, 3'd0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step();
        chk("final_empty", {31'd0, out_if.valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
